// File: rtl/hc32_tester_if.sv
// hc32_tester_if: board pins of a quad 2-input OR device (tester drives A/B, reads Y).
interface hc32_tester_if #(parameter int NUM_GATES = 4);
  logic [NUM_GATES-1:0] a_out;
  logic [NUM_GATES-1:0] b_out;
  logic [NUM_GATES-1:0] y_in;
  modport master (output a_out, b_out, input y_in);
  modport slave (input a_out, b_out, output y_in);
endinterface

// File: rtl/hc32_tester.sv
// hc32_tester: applies all four OR-gate input vectors to every gate and accumulates a per-gate fault mask.
module hc32_tester #(
  parameter int NUM_GATES = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  hc32_tester_if.master        pins,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask
);
  if (SETTLE_CYCLES < 2 || (CNT_W < 31 && (1 << CNT_W) <= SETTLE_CYCLES)) begin : g_bad_params
    $error("hc32_tester: SETTLE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  state_t               r_state, w_next;
  logic [1:0]           r_v;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_GATES-1:0] r_y1, r_y_s, r_fail_mask;
  logic                 r_pass, w_drive;
  logic [NUM_GATES-1:0] w_exp, w_mask_next;
  assign w_exp = {NUM_GATES{r_v[1] | r_v[0]}};
  assign w_mask_next = r_fail_mask | (r_y_s ^ w_exp);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? DRIVE : IDLE;
      DRIVE:   w_next = SETTLE;
      SETTLE:  w_next = (r_cnt == CNT_W'(1)) ? SAMPLE : SETTLE;
      SAMPLE:  w_next = (r_v == 2'd3) ? DONE : DRIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // y_in is asynchronous to clk, so it only reaches the compare through two flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_y1        <= '0;
      r_y_s       <= '0;
      r_v         <= '0;
      r_cnt       <= '0;
      r_fail_mask <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_y1  <= pins.y_in;
      r_y_s <= r_y1;
      if (r_state == IDLE && start) begin
        r_v         <= '0;
        r_fail_mask <= '0;
        r_pass      <= 1'b0;
      end
      if (r_state == DRIVE) r_cnt <= CNT_W'(SETTLE_CYCLES);
      if (r_state == SETTLE) r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == SAMPLE) begin
        r_fail_mask <= w_mask_next;
        if (r_v == 2'd3) r_pass <= (w_mask_next == '0);
        else r_v <= r_v + 2'd1;
      end
    end
  always_comb begin
    w_drive    = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
    pins.a_out = w_drive ? {NUM_GATES{r_v[1]}} : '0;
    pins.b_out = w_drive ? {NUM_GATES{r_v[0]}} : '0;
    busy       = w_drive;
    done       = (r_state == DONE);
  end
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;
endmodule

// File: tb/tb_hc32_tester.sv
// tb_hc32_tester: randomized runs of hc32_tester against a fault-injecting OR-device model.
module tb_hc32_tester;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [3:0] fail_mask;
  logic [3:0] s0 = '0, s1 = '0;
  int errors = 0, checks = 0;

  hc32_tester_if #(.NUM_GATES(4)) pins ();
  hc32_tester #(.NUM_GATES(4), .SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pins(pins),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
  );

  // external device: ideal OR with per-gate stuck-at-0 / stuck-at-1 overrides
  assign pins.y_in = ((pins.a_out | pins.b_out) & ~s0) | s1;

  always #5 clk = ~clk;

  function automatic logic [3:0] model_mask(input logic [3:0] st0, input logic [3:0] st1);
    logic [3:0] m = '0;
    for (int v = 0; v < 4; v++)
      for (int g = 0; g < 4; g++) begin
        bit good = (v != 0);
        bit seen = st1[g] ? 1'b1 : (st0[g] ? 1'b0 : good);
        if (seen != good) m[g] = 1'b1;
      end
    return m;
  endfunction

  task automatic run(input logic [3:0] st0, input logic [3:0] st1, input bit spam, input string name);
    logic [3:0] exp_mask, ea, eb;
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, drive_err = 0;
    s0 = st0; s1 = st1;
    exp_mask = model_mask(st0, st1);
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = (spam && k < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == 1) begin
        checks++;
        if (fail_mask !== 4'b0 || pass !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s start_clear: fail_mask=%b pass=%b busy=%b, want 0000 0 1", name, fail_mask, pass, busy);
        end
      end
      ea = (k <= 24 && ((k - 1) / 6) >= 2) ? 4'hf : 4'h0;
      eb = (k <= 24 && ((k - 1) / 6) % 2 == 1) ? 4'hf : 4'h0;
      if (pins.a_out !== ea || pins.b_out !== eb) drive_err++;
      if (done === 1'b1) begin done_cnt++; done_cyc = k; end
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 25) begin
      errors++;
      $display("FAIL %s done_timing: count=%0d cycle=%0d, want 1 at 25", name, done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt != 24) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles, want 24", name, busy_cnt);
    end
    checks++;
    if (drive_err != 0) begin
      errors++;
      $display("FAIL %s drive_pattern: %0d bad cycles, want 0", name, drive_err);
    end
    checks++;
    if (fail_mask !== exp_mask || pass !== (exp_mask == 4'b0)) begin
      errors++;
      $display("FAIL %s result: fail_mask=%b pass=%b, want %b %b", name, fail_mask, pass, exp_mask, exp_mask == 4'b0);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (pins.a_out !== 4'b0 || pins.b_out !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_mask !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: a=%b b=%b busy=%b done=%b pass=%b mask=%b, want all 0", pins.a_out, pins.b_out, busy, done, pass, fail_mask);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ideal();         run(4'b0000, 4'b0000, 1'b0, "ideal");      endtask
  task automatic test_stuck0_gate2();  run(4'b0100, 4'b0000, 1'b0, "stuck0_g2");  endtask
  task automatic test_stuck1_gate0();  run(4'b0000, 4'b0001, 1'b0, "stuck1_g0");  endtask

  task automatic test_ignored_start();
    int extra = 0;
    run(4'b0000, 4'b0000, 1'b1, "start_spam");
    repeat (10) begin @(posedge clk); #1; if (busy === 1'b1 || done === 1'b1) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_queued: %0d busy/done cycles after run, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int dcnt = 0;
    s0 = '0; s1 = '0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 15; k++) begin @(posedge clk); #1; start = 1'b0; end
    checks++;
    if (pins.a_out !== 4'hf || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: a=%b busy=%b, want 1111 1", pins.a_out, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pins.a_out !== 4'b0 || pins.b_out !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail_mask !== 4'b0) begin
      errors++;
      $display("FAIL async_abort: a=%b b=%b busy=%b done=%b pass=%b mask=%b, want all 0", pins.a_out, pins.b_out, busy, done, pass, fail_mask);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) dcnt++; end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL abort_done: %0d busy/done cycles after abort, want 0", dcnt);
    end
    run(4'b0000, 4'b0000, 1'b0, "after_abort");
  endtask

  task automatic test_fail_then_pass();
    run(4'b0100, 4'b0000, 1'b0, "fail_first");
    run(4'b0000, 4'b0000, 1'b0, "pass_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] r0 = 4'($urandom), r1 = 4'($urandom);
      run(r0, r1 & 4'($urandom), 1'(i % 2), $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck0_gate2();
    test_stuck1_gate0();
    test_ignored_start();
    test_reset_mid_run();
    test_fail_then_pass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
